// File: rtl/draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : draw_scheduler
// Purpose : Runs one drawing job (optional screen clear, then shape) and
//           muxes, clips and counts the active engine's plots onto the VGA port.
// Revision: 1.0 - initial release
// ============================================================================
module draw_scheduler #(
    parameter int unsigned SCREEN_W = 160,
    parameter int unsigned SCREEN_H = 120,
    parameter bit          CLEAR_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        start,
    output logic        done,
    output logic        busy,

    output logic        fs_start,
    input  logic        fs_done,
    input  logic [7:0]  fs_x,
    input  logic [6:0]  fs_y,
    input  logic [2:0]  fs_colour,
    input  logic        fs_plot,

    output logic        sh_start,
    input  logic        sh_done,
    input  logic [7:0]  sh_x,
    input  logic [6:0]  sh_y,
    input  logic [2:0]  sh_colour,
    input  logic        sh_plot,

    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_plot,

    output logic [14:0] pix_count
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_DRAW  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // One extra bit so a screen size equal to the coordinate range still works.
    localparam logic [8:0]  c_screen_w = 9'(SCREEN_W);
    localparam logic [7:0]  c_screen_h = 8'(SCREEN_H);
    localparam logic [14:0] c_pix_max  = 15'h7FFF;

    state_t      r_state;
    state_t      w_next;

    logic        w_active;
    logic [7:0]  w_sel_x;
    logic [6:0]  w_sel_y;
    logic [2:0]  w_sel_colour;
    logic        w_sel_plot;
    logic        w_on_screen;
    logic        w_plot_next;
    logic        w_job_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (start)   w_next = CLEAR_EN ? S_CLEAR : S_DRAW;
            S_CLEAR: if (fs_done) w_next = S_DRAW;
            S_DRAW:  if (sh_done) w_next = S_DONE;
            S_DONE:  if (!start)  w_next = S_IDLE;
            default:              w_next = S_IDLE;
        endcase
    end

    // Source select follows the current state, so a plot issued together with
    // the engine's done is still forwarded.
    always_comb begin
        w_active     = (r_state == S_CLEAR) || (r_state == S_DRAW);
        w_sel_x      = sh_x;
        w_sel_y      = sh_y;
        w_sel_colour = sh_colour;
        w_sel_plot   = 1'b0;
        if (r_state == S_CLEAR) begin
            w_sel_x      = fs_x;
            w_sel_y      = fs_y;
            w_sel_colour = fs_colour;
            w_sel_plot   = fs_plot;
        end else if (r_state == S_DRAW) begin
            w_sel_plot   = sh_plot;
        end
        w_on_screen = ({1'b0, w_sel_x} < c_screen_w) && ({1'b0, w_sel_y} < c_screen_h);
        w_plot_next = w_sel_plot && w_on_screen;
        w_job_start = (r_state == S_IDLE) && start;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            done       <= 1'b0;
            busy       <= 1'b0;
            fs_start   <= 1'b0;
            sh_start   <= 1'b0;
            vga_x      <= 8'd0;
            vga_y      <= 7'd0;
            vga_colour <= 3'd0;
            vga_plot   <= 1'b0;
            pix_count  <= 15'd0;
        end else begin
            done     <= (w_next == S_DONE);
            busy     <= (w_next == S_CLEAR) || (w_next == S_DRAW);
            fs_start <= (w_next == S_CLEAR);
            sh_start <= (w_next == S_DRAW);
            if (w_active) begin
                vga_x      <= w_sel_x;
                vga_y      <= w_sel_y;
                vga_colour <= w_sel_colour;
            end
            vga_plot <= w_plot_next;
            if (w_job_start) begin
                pix_count <= 15'd0;
            end else if (w_plot_next && (pix_count != c_pix_max)) begin
                pix_count <= pix_count + 15'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_draw_scheduler.sv
`default_nettype none
// ============================================================================
// Module  : tb_draw_scheduler
// Purpose : Scoreboard bench for draw_scheduler with directed job sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_draw_scheduler;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_b;
    logic        fs_done, sh_done, fs_plot, sh_plot;
    logic [7:0]  fs_x, sh_x;
    logic [6:0]  fs_y, sh_y;
    logic [2:0]  fs_colour, sh_colour;

    logic        done, busy, fs_start, sh_start, vga_plot;
    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic [14:0] pix_count;

    logic        b_done, b_busy, b_fs_start, b_sh_start, b_vga_plot;
    logic [7:0]  b_vga_x;
    logic [6:0]  b_vga_y;
    logic [2:0]  b_vga_colour;
    logic [14:0] b_pix_count;

    int          n_vec = 0;
    int          n_err = 0;
    bit          mon_en = 1'b0;
    logic [17:0] exp_q[$];
    int          exp_count;

    always #5 clk = ~clk;

    draw_scheduler #(.SCREEN_W(160), .SCREEN_H(120), .CLEAR_EN(1'b1)) dut (
        .clk(clk), .rst(rst), .start(start), .done(done), .busy(busy),
        .fs_start(fs_start), .fs_done(fs_done), .fs_x(fs_x), .fs_y(fs_y),
        .fs_colour(fs_colour), .fs_plot(fs_plot),
        .sh_start(sh_start), .sh_done(sh_done), .sh_x(sh_x), .sh_y(sh_y),
        .sh_colour(sh_colour), .sh_plot(sh_plot),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour), .vga_plot(vga_plot),
        .pix_count(pix_count)
    );

    draw_scheduler #(.SCREEN_W(160), .SCREEN_H(120), .CLEAR_EN(1'b0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .done(b_done), .busy(b_busy),
        .fs_start(b_fs_start), .fs_done(fs_done), .fs_x(fs_x), .fs_y(fs_y),
        .fs_colour(fs_colour), .fs_plot(fs_plot),
        .sh_start(b_sh_start), .sh_done(sh_done), .sh_x(sh_x), .sh_y(sh_y),
        .sh_colour(sh_colour), .sh_plot(sh_plot),
        .vga_x(b_vga_x), .vga_y(b_vga_y), .vga_colour(b_vga_colour), .vga_plot(b_vga_plot),
        .pix_count(b_pix_count)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    task automatic push_plot(input logic [7:0] x, input logic [6:0] y, input logic [2:0] c);
        exp_q.push_back({x, y, c});
        exp_count++;
    endtask

    // Every forwarded plot must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (mon_en && (vga_plot === 1'b1)) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_plot: got x=%0d y=%0d c=%0d expected no plot",
                         vga_x, vga_y, vga_colour);
            end else begin
                logic [17:0] e;
                e = exp_q.pop_front();
                if ({vga_x, vga_y, vga_colour} !== e) begin
                    n_err++;
                    $display("FAIL plot_data: got x=%0d y=%0d c=%0d expected x=%0d y=%0d c=%0d",
                             vga_x, vga_y, vga_colour, e[17:10], e[9:3], e[2:0]);
                end
            end
        end
    end

    task automatic idle_engines();
        fs_done = 0; sh_done = 0; fs_plot = 0; sh_plot = 0;
        fs_x = 0; fs_y = 0; fs_colour = 0;
        sh_x = 0; sh_y = 0; sh_colour = 0;
    endtask

    initial begin
        exp_count = 0;
        start = 0; start_b = 0;
        rst = 1;
        for (int i = 0; i < 2; i++) begin
            fs_done = 1'($urandom); sh_done = 1'($urandom);
            fs_plot = 1'b1; sh_plot = 1'($urandom);
            fs_x = 8'($urandom); fs_y = 7'($urandom); fs_colour = 3'($urandom);
            sh_x = 8'($urandom); sh_y = 7'($urandom); sh_colour = 3'($urandom);
            tick();
        end
        chk("rst_done", done, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fs_start", fs_start, 0);
        chk("rst_sh_start", sh_start, 0);
        chk("rst_vga_plot", vga_plot, 0);
        chk("rst_vga_xyc", {vga_x, vga_y, vga_colour}, 0);
        chk("rst_pix_count", pix_count, 0);

        rst = 0;
        idle_engines();
        mon_en = 1'b1;
        tick();

        // Full job with screen clear.
        start = 1;
        chk("fs_start_before", fs_start, 0);
        tick();
        chk("fs_start_rise", fs_start, 1);
        chk("busy_clear", busy, 1);
        chk("pix_count_job_start", pix_count, 0);
        sh_plot = 1; sh_x = 8'd7; sh_y = 7'd3; sh_colour = 3'd5;
        for (int y = 0; y < 120; y++) begin
            for (int x = 0; x < 160; x++) begin
                fs_x = 8'(x); fs_y = 7'(y); fs_colour = 3'd0; fs_plot = 1;
                sh_done = (y == 5 && x == 0);
                fs_done = (y == 119 && x == 159);
                push_plot(8'(x), 7'(y), 3'd0);
                tick();
            end
        end
        idle_engines();
        chk("sh_start_rise", sh_start, 1);
        chk("fs_start_fall", fs_start, 0);
        chk("pix_count_clear", pix_count, 15'd19200);

        // Clipping and isolation in DRAW.
        sh_x = 8'd160; sh_y = 7'd10; sh_colour = 3'd1; sh_plot = 1;
        tick();
        chk("clip_x_vga_x", vga_x, 160);
        chk("clip_x_plot", vga_plot, 0);
        chk("clip_x_count", pix_count, 15'd19200);
        sh_x = 8'd159; sh_y = 7'd119;
        push_plot(8'd159, 7'd119, 3'd1);
        tick();
        chk("edge_plot", vga_plot, 1);
        sh_x = 8'd3; sh_y = 7'd120;
        tick();
        chk("clip_y_plot", vga_plot, 0);
        chk("clip_y_vga_y", vga_y, 120);
        sh_plot = 0; sh_x = 8'd9; sh_y = 7'd9;
        fs_plot = 1; fs_x = 8'd5; fs_y = 7'd5; fs_done = 1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("iso_vga_x", vga_x, 9);
            chk("iso_state", {busy, sh_start, done}, 3'b110);
        end
        chk("iso_count", pix_count, 15'd19201);
        idle_engines();
        for (int i = 0; i < 100; i++) begin
            sh_x = 8'(i); sh_y = 7'(i); sh_colour = 3'd1; sh_plot = 1;
            sh_done = (i == 99);
            push_plot(8'(i), 7'(i), 3'd1);
            tick();
        end
        idle_engines();
        chk("done_rise", done, 1);
        chk("busy_fall", busy, 0);
        chk("sh_start_fall", sh_start, 0);
        chk("pix_count_job", pix_count, 15'd19301);

        // Done handshake with start held.
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("done_hold", {done, busy}, 2'b10);
        end
        chk("pix_count_hold", pix_count, 15'd19301);
        start = 0;
        tick();
        chk("done_fall", done, 0);
        start = 1;
        tick();
        chk("restart_count", pix_count, 0);
        chk("restart_fs_start", fs_start, 1);
        exp_count = 0;
        fs_done = 1;
        tick();
        fs_done = 0;
        chk("restart_sh_start", sh_start, 1);

        // Reset mid-DRAW at plot #50.
        for (int i = 0; i < 49; i++) begin
            sh_x = 8'(i + 10); sh_y = 7'(i); sh_colour = 3'd2; sh_plot = 1;
            push_plot(8'(i + 10), 7'(i), 3'd2);
            tick();
        end
        chk("pre_rst_count", pix_count, 15'd49);
        sh_x = 8'd60; sh_y = 7'd60; rst = 1; start = 0;
        tick();
        rst = 0;
        idle_engines();
        chk("midrst_sh_start", sh_start, 0);
        chk("midrst_plot", vga_plot, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_count", pix_count, 0);

        // CLEAR_EN=0 instance goes straight to DRAW.
        start_b = 1;
        tick();
        chk("b_sh_start", b_sh_start, 1);
        chk("b_fs_start", b_fs_start, 0);
        chk("b_busy", b_busy, 1);
        fs_done = 1;
        tick();
        fs_done = 0;
        chk("b_fs_stray", {b_fs_start, b_sh_start}, 2'b01);
        sh_done = 1;
        tick();
        sh_done = 0;
        start_b = 0;
        chk("b_done", {b_done, b_fs_start}, 2'b10);
        tick();
        chk("b_done_fall", b_done, 0);
        chk("a_stays_idle", {busy, done}, 2'b00);

        tick();
        tick();
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
